// File: rtl/kbd_event_decoder_if.sv
// Event stream from the decoder: valid/ready handshake plus head-entry fields.
// The decoder drives the master side; the display/host consumer is the slave.
interface kbd_event_decoder_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/kbd_event_decoder.sv
// PS/2 set-2 bytes -> make/break events via FIFO, plus display status; KBD_ASCII_EN builds the ASCII lookup.
// Latency: 1 cycle byte_valid -> ev/status; byte input has no backpressure, full FIFO drops and sets drop_flag.
module kbd_event_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    kbd_event_decoder_if.master        ev,
    output logic [7:0]                 cur_code,
    output logic [7:0]                 cur_ascii,
    output logic                       key_down,
    output logic [7:0]                 press_cnt,
    output logic                       drop_flag
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t      state;
    ev_t         mem [FIFO_DEPTH];
    ev_t         head;
    ev_t         new_ev;
    logic [PW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [8:0]  held;

    logic is_e0, is_f0, is_data;
    logic ext_c, brk_c, repeat_c;
    logic push_req, push_ok, pop, full, empty;

    assign is_e0   = (byte_in == 8'hE0);
    assign is_f0   = (byte_in == 8'hF0);
    assign is_data = byte_valid && !is_e0 && !is_f0;
    assign ext_c   = (state == EXT) || (state == EXT_BRK);
    assign brk_c   = (state == BRK) || (state == EXT_BRK);

    // A make of the key already held down is a typematic repeat and is swallowed.
    assign repeat_c = !brk_c && key_down && (held == {ext_c, byte_in});
    assign push_req = is_data && !repeat_c;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop     = !empty && ev.ev_ready;
    assign push_ok = push_req && (!full || pop);
    assign new_ev  = '{code: byte_in, ext: ext_c, brk: brk_c};
    assign wr_nxt  = wr_ptr + {{PW{1'b0}}, push_ok};
    assign rd_nxt  = rd_ptr + {{PW{1'b0}}, pop};

    assign ev.ev_valid = !empty;
    assign ev.ev_code  = head.code;
    assign ev.ev_ext   = head.ext;
    assign ev.ev_break = head.brk;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (push_ok) mem[wr_ptr[PW-1:0]] <= new_ev;
            // Head is registered; when the FIFO drains to just the incoming entry, take it directly.
            if (wr_nxt != rd_nxt)
                head <= (rd_nxt == wr_ptr) ? new_ev : mem[rd_nxt[PW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cur_code  <= 8'h00;
            key_down  <= 1'b0;
            press_cnt <= 8'h00;
            drop_flag <= 1'b0;
            held      <= 9'h000;
        end else begin
            if (byte_valid) begin
                case (state)
                    IDLE:    state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                    EXT:     state <= is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
                    BRK:     state <= is_e0 ? EXT_BRK : (is_f0 ? BRK : IDLE);
                    EXT_BRK: state <= (is_e0 || is_f0) ? EXT_BRK : IDLE;
                    default: state <= IDLE;
                endcase
            end
            if (is_data) begin
                if (!brk_c && !repeat_c) begin
                    press_cnt <= press_cnt + 8'd1;
                    key_down  <= 1'b1;
                    held      <= {ext_c, byte_in};
                    cur_code  <= byte_in;
                end else if (brk_c && (held == {ext_c, byte_in})) begin
                    key_down  <= 1'b0;
                end
            end
            if (push_req && !push_ok) drop_flag <= 1'b1;
        end
    end

`ifdef KBD_ASCII_EN
    logic [7:0] ascii_q;

    function automatic logic [7:0] set2_ascii(input logic ext, input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: a = "a"; 8'h32: a = "b"; 8'h21: a = "c"; 8'h23: a = "d";
                8'h24: a = "e"; 8'h2B: a = "f"; 8'h34: a = "g"; 8'h33: a = "h";
                8'h43: a = "i"; 8'h3B: a = "j"; 8'h42: a = "k"; 8'h4B: a = "l";
                8'h3A: a = "m"; 8'h31: a = "n"; 8'h44: a = "o"; 8'h4D: a = "p";
                8'h15: a = "q"; 8'h2D: a = "r"; 8'h1B: a = "s"; 8'h2C: a = "t";
                8'h3C: a = "u"; 8'h2A: a = "v"; 8'h1D: a = "w"; 8'h22: a = "x";
                8'h35: a = "y"; 8'h1A: a = "z";
                8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3";
                8'h25: a = "4"; 8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7";
                8'h3E: a = "8"; 8'h46: a = "9";
                8'h29: a = 8'h20;
                8'h5A: a = 8'h0D;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ascii_q <= 8'h00;
        else if (is_data && !brk_c && !repeat_c)
            ascii_q <= set2_ascii(ext_c, byte_in);
    end

    assign cur_ascii = ascii_q;
`else
    assign cur_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Randomized and directed bench for kbd_event_decoder against a prefix-flag/queue reference model.
module tb_kbd_event_decoder;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [7:0] cur_code, cur_ascii, press_cnt;
    logic       key_down, drop_flag;

    kbd_event_decoder_if ev ();

    kbd_event_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .ev         (ev.master),
        .cur_code   (cur_code),
        .cur_ascii  (cur_ascii),
        .key_down   (key_down),
        .press_cnt  (press_cnt),
        .drop_flag  (drop_flag)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_s;

    ev_s        q[$];
    ev_s        m_head;
    logic [7:0] m_cur, m_ascii, m_cnt;
    logic [8:0] m_held;
    bit         m_down, m_drop, m_ext, m_brk;
    int         m_pushes;

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [10]    = '{8'h1C, 8'h1B, 8'h15, 8'h75, 8'h5A, 8'h29, 8'h45, 8'hE0, 8'hF0, 8'h33};

    function automatic logic [7:0] ascii_ref(input bit ext, input logic [7:0] c);
`ifdef KBD_ASCII_EN
        if (ext) return 8'h00;
        for (int i = 0; i < 26; i++) if (letters[i] == c) return 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        return 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_head = '0; m_cur = 0; m_ascii = 0; m_cnt = 0; m_held = 0;
        m_down = 0; m_drop = 0; m_ext = 0; m_brk = 0;
    endtask

    task automatic model_edge(input logic [7:0] b, input bit v, input bit rdy);
        bit  pop, push;
        ev_s e;
        pop  = (q.size() > 0) && rdy;
        push = 0;
        e    = '0;
        if (v) begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                e = '{code: b, ext: m_ext, brk: m_brk};
                if (!m_brk) begin
                    if (!(m_down && m_held == {m_ext, b})) begin
                        push = 1;
                        m_cnt++;
                        m_down = 1;
                        m_held = {m_ext, b};
                        m_cur = b;
                        m_ascii = ascii_ref(m_ext, b);
                    end
                end else begin
                    push = 1;
                    if (m_held == {m_ext, b}) m_down = 0;
                end
                m_ext = 0;
                m_brk = 0;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            m_pushes++;
            if (q.size() < DEPTH) q.push_back(e);
            else m_drop = 1;
        end
        if (q.size() > 0) m_head = q[0];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, ev.ev_valid, q.size() > 0);
        chk({tag, ".code"},  ev.ev_code,  m_head.code);
        chk({tag, ".ext"},   ev.ev_ext,   m_head.ext);
        chk({tag, ".brk"},   ev.ev_break, m_head.brk);
        chk({tag, ".cur"},   cur_code,    m_cur);
        chk({tag, ".ascii"}, cur_ascii,   m_ascii);
        chk({tag, ".down"},  key_down,    m_down);
        chk({tag, ".cnt"},   press_cnt,   m_cnt);
        chk({tag, ".drop"},  drop_flag,   m_drop);
    endtask

    task automatic step(input string tag, input logic [7:0] b, input bit v, input bit rdy);
        byte_in = b;
        byte_valid = v;
        ev.ev_ready = rdy;
        @(posedge clk);
        model_edge(b, v, rdy);
        #1;
        check_all(tag);
    endtask

    // Inputs deliberately show a valid byte during reset; it must be ignored.
    task automatic do_reset();
        resetn = 1'b0;
        byte_in = 8'h1C;
        byte_valid = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("rst");
        resetn = 1'b1;
        byte_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [5];
        logic [7:0] exp_ascii;
        int         base;
        bit         rdy_hi;
`ifdef KBD_ASCII_EN
        exp_ascii = 8'h61;
`else
        exp_ascii = 8'h00;
`endif
        ev.ev_ready = 1'b1;
        do_reset();

        step("t1", 8'h1C, 1, 1);
        chk("t1.valid", ev.ev_valid, 1);
        chk("t1.code", ev.ev_code, 8'h1C);
        chk("t1.brk", ev.ev_break, 0);
        chk("t1.cnt", press_cnt, 1);
        chk("t1.down", key_down, 1);
        chk("t1.ascii", cur_ascii, exp_ascii);

        do_reset();
        base = m_pushes;
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        for (int i = 0; i < 5; i++) step("t2", seq[i], 1, 1);
        chk("t2.events", m_pushes - base, 2);
        chk("t2.cnt", press_cnt, 1);
        chk("t2.down", key_down, 0);
        chk("t2.brk", ev.ev_break, 1);

        do_reset();
        step("t3", 8'hE0, 1, 1);
        step("t3", 8'h75, 1, 1);
        chk("t3.mk_code", ev.ev_code, 8'h75);
        chk("t3.mk_ext", ev.ev_ext, 1);
        chk("t3.mk_brk", ev.ev_break, 0);
        chk("t3.down1", key_down, 1);
        chk("t3.ascii", cur_ascii, 0);
        step("t3", 8'hE0, 1, 1);
        step("t3", 8'hF0, 1, 1);
        step("t3", 8'h75, 1, 1);
        chk("t3.bk_ext", ev.ev_ext, 1);
        chk("t3.bk_brk", ev.ev_break, 1);
        chk("t3.down0", key_down, 0);

        do_reset();
        seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        for (int i = 0; i < 5; i++) step("t4", seq[i], 1, 0);
        chk("t4.valid", ev.ev_valid, 1);
        chk("t4.head", ev.ev_code, 8'h15);
        chk("t4.drop", drop_flag, 1);
        chk("t4.cnt", press_cnt, 5);
        chk("t4.cur", cur_code, 8'h2C);
        for (int i = 0; i < 4; i++) begin
            chk("t4.drain", ev.ev_code, seq[i]);
            step("t4d", 8'h00, 0, 1);
        end
        chk("t4.empty", ev.ev_valid, 0);

        do_reset();
        for (int i = 0; i < 256; i++) step("t5", (i % 2 == 0) ? 8'h1C : 8'h1B, 1, 1);
        chk("t5.wrap", press_cnt, 8'h00);

        do_reset();
        step("t6", 8'hF0, 1, 1);
        do_reset();
        step("t6", 8'h1C, 1, 1);
        chk("t6.code", ev.ev_code, 8'h1C);
        chk("t6.brk", ev.ev_break, 0);
        chk("t6.cnt", press_cnt, 1);
        chk("t6.drop", drop_flag, 0);

        do_reset();
        rdy_hi = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) rdy_hi = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step("rnd", pool[$urandom_range(0, 9)], ($urandom_range(0, 2) != 0),
                      rdy_hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
